conv_pe_lb: RTL and testbench

Parametrised streaming 2-D convolution PE. It supersedes the fixed 9-bit, 3x3 shift-register PE.
- Holds a KxK signed kernel, loaded serially.
- Buffers K-1 image rows internally in line buffers.
- Emits one signed dot product per valid window position.
- Sits between the feature-map streamer and the pooling/activation stage.
- Adds over the previous PE: valid qualification, border suppression, frame restart, signed arithmetic, generic K and IMG_W.

---
 rtl/conv_pkg.sv | 26 ++
 rtl/conv_line_buf.sv | 33 +++
 rtl/conv_pe_lb.sv | 205 ++++++++++++++++++++
 tb/tb_conv_pe_lb.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | conv_pkg                                                           |
// | Shared types, FSM encoding and width helper for conv_pe_lb.        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package conv_pkg;

  localparam int DEF_DATA_W = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  typedef logic signed [DEF_DATA_W-1:0] pix_t;
  typedef logic signed [DEF_DATA_W-1:0] weight_t;

  // Full-precision accumulator width: one product plus growth for K*K terms.
  function automatic int acc_w_f(input int data_w, input int k);
    return 2 * data_w + $clog2(k * k);
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_line_buf.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | conv_line_buf                                                      |
// | DATA_W x DEPTH enabled shift buffer; dout is the DEPTH-old sample. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module conv_line_buf
  import conv_pkg::*;
#(
  parameter int DATA_W = 9,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] r_sr [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      r_sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        r_sr[i] <= r_sr[i-1];
      end
    end
  end

  assign dout = r_sr[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/conv_pe_lb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | conv_pe_lb                                                         |
// | Streaming KxK signed convolution PE with internal line buffers.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module conv_pe_lb
  import conv_pkg::*;
#(
  parameter int DATA_W = 9,
  parameter int K      = 3,
  parameter int IMG_W  = 32,
  parameter int ACC_W  = acc_w_f(DATA_W, K)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              w_valid,
  input  logic [DATA_W-1:0] w_in,
  output logic              w_ready,
  output logic              run_ready,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_in,
  input  logic              frame_start,
  output logic              out_valid,
  output logic [ACC_W-1:0]  data_out
);

  localparam int KK = K * K;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(K);
  localparam int IW = $clog2(KK);
  localparam int PW = 2 * DATA_W;
  localparam logic [CW-1:0] C_COL_LAST  = CW'(IMG_W - 1);
  localparam logic [CW-1:0] C_COL_FIRST = CW'(K - 1);
  localparam logic [RW-1:0] C_ROW_LAST  = RW'(K - 1);
  localparam logic [IW-1:0] C_IDX_LAST  = IW'(KK - 1);

  typedef logic signed [DATA_W-1:0] sdata_t;
  typedef logic signed [PW-1:0]     prod_t;

  state_e            r_state;
  logic [IW-1:0]     r_idx;
  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  sdata_t            r_kern [KK];
  sdata_t            r_win  [K][K];
  prod_t             r_prod [KK];
  logic              r_v0;
  logic              r_v1;

  logic              w_accept;
  logic [CW-1:0]     w_col_now;
  logic [RW-1:0]     w_row_now;
  logic              w_win_ok;
  logic [DATA_W-1:0] w_lb_in  [K-1];
  logic [DATA_W-1:0] w_lb_out [K-1];
  logic [DATA_W-1:0] w_col_in [K];
  logic [ACC_W-1:0]  w_sum;

  assign w_accept  = pix_valid && run_ready;
  assign w_col_now = frame_start ? '0 : r_col;
  assign w_row_now = frame_start ? '0 : r_row;
  // Row saturates at K-1, so equality means K-1 full rows precede this pixel.
  assign w_win_ok  = (w_row_now == C_ROW_LAST) && (w_col_now >= C_COL_FIRST);

  generate
    for (genvar j = 0; j < K - 1; j++) begin : g_lb
      if (j == 0) begin : g_head
        assign w_lb_in[j] = pix_in;
      end else begin : g_chain
        assign w_lb_in[j] = w_lb_out[j-1];
      end
      conv_line_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_W)
      ) u_line_buf (
        .clk  (clk),
        .en   (w_accept),
        .din  (w_lb_in[j]),
        .dout (w_lb_out[j])
      );
    end
  endgenerate

  // New right-hand window column, oldest row at index 0.
  always_comb begin
    w_col_in[K-1] = pix_in;
    for (int r = 0; r < K - 1; r++) begin
      w_col_in[r] = w_lb_out[K-2-r];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      w_ready   <= 1'b0;
      run_ready <= 1'b0;
      r_idx     <= '0;
      r_col     <= '0;
      r_row     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (load_start) begin
            r_state <= LOAD;
            w_ready <= 1'b1;
            r_idx   <= '0;
          end
        end
        LOAD: begin
          if (load_start) begin
            r_idx <= '0;
          end else if (w_valid) begin
            if (r_idx == C_IDX_LAST) begin
              r_state   <= RUN;
              w_ready   <= 1'b0;
              run_ready <= 1'b1;
              r_idx     <= '0;
              r_col     <= '0;
              r_row     <= '0;
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end
        end
        RUN: begin
          if (load_start) begin
            r_state   <= LOAD;
            w_ready   <= 1'b1;
            run_ready <= 1'b0;
            r_idx     <= '0;
            r_col     <= '0;
            r_row     <= '0;
          end else if (w_accept) begin
            if (w_col_now == C_COL_LAST) begin
              r_col <= '0;
              r_row <= (w_row_now == C_ROW_LAST) ? w_row_now : w_row_now + RW'(1);
            end else begin
              r_col <= w_col_now + CW'(1);
              r_row <= w_row_now;
            end
          end
        end
        default: begin
          r_state   <= IDLE;
          w_ready   <= 1'b0;
          run_ready <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == LOAD && w_valid && !load_start) begin
      r_kern[r_idx] <= sdata_t'(w_in);
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          r_win[r][c] <= r_win[r][c+1];
        end
        r_win[r][K-1] <= sdata_t'(w_col_in[r]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_v0) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          r_prod[r*K+c] <= prod_t'(r_kern[r*K+c]) * prod_t'(r_win[r][c]);
        end
      end
    end
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < KK; i++) begin
      w_sum = w_sum + {{(ACC_W-PW){r_prod[i][PW-1]}}, r_prod[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v0      <= 1'b0;
      r_v1      <= 1'b0;
      out_valid <= 1'b0;
      data_out  <= '0;
    end else begin
      r_v0      <= w_accept && w_win_ok;
      r_v1      <= r_v0;
      out_valid <= r_v1;
      if (r_v1) begin
        data_out <= w_sum;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_pe_lb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_conv_pe_lb                                                      |
// | Randomized scoreboard bench for conv_pe_lb against a frame model.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_conv_pe_lb;
  import conv_pkg::*;

  localparam int DW = 9;
  localparam int K  = 3;
  localparam int W  = 32;
  localparam int AW = 22;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_start = 1'b0;
  logic          w_valid = 1'b0;
  logic [DW-1:0] w_in = '0;
  logic          w_ready;
  logic          run_ready;
  logic          pix_valid = 1'b0;
  logic [DW-1:0] pix_in = '0;
  logic          frame_start = 1'b0;
  logic          out_valid;
  logic [AW-1:0] data_out;

  always #5 clk = ~clk;

  conv_pe_lb dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_start  (load_start),
    .w_valid     (w_valid),
    .w_in        (w_in),
    .w_ready     (w_ready),
    .run_ready   (run_ready),
    .pix_valid   (pix_valid),
    .pix_in      (pix_in),
    .frame_start (frame_start),
    .out_valid   (out_valid),
    .data_out    (data_out)
  );

  typedef struct {
    int val;
    int due;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_out    = 0;
  int   cyc      = 0;
  int   kern  [K*K];
  int   new_k [K*K];
  int   img   [16][W];
  int   m_x = 0;
  int   m_y = 0;
  bit   m_run = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every presented result must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      n_out++;
      if (sb.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        m_e = sb.pop_front();
        chk("data_out", $signed(data_out), m_e.val);
        chk("out_cycle", cyc, m_e.due);
      end
    end
  end

  // Reference: place the pixel in its frame position; windows are plain sums.
  task automatic ref_pixel(input int v, input bit fs);
    int s;
    if (fs) begin
      m_x = 0;
      m_y = 0;
    end
    img[m_y % 16][m_x] = v;
    if (m_y >= K - 1 && m_x >= K - 1) begin
      s = 0;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          s += kern[r*K+c] * img[(m_y - (K-1) + r) % 16][m_x - (K-1) + c];
      sb.push_back('{val: s, due: cyc + 3});
    end
    m_x++;
    if (m_x == W) begin
      m_x = 0;
      m_y++;
    end
  endtask

  task automatic drive_pix(input int v, input bit fs, input bit valid);
    pix_valid   = valid;
    pix_in      = DW'(v);
    frame_start = fs;
    if (valid && m_run) ref_pixel(v, fs);
    @(negedge clk);
    pix_valid   = 1'b0;
    frame_start = 1'b0;
  endtask

  // mode: 0 const 2, 1 ramp mod 200, 2 const 255, 3 random; gap: 0 none, 1 alternate, 2 random
  task automatic stream(input int npix, input int mode, input bit fs, input int gap);
    int v;
    for (int i = 0; i < npix; i++) begin
      case (mode)
        0:       v = 2;
        1:       v = ((i / W) * 32 + (i % W)) % 200;
        2:       v = 255;
        default: v = int'($urandom_range(0, 511)) - 256;
      endcase
      if (gap == 1 && i != 0) drive_pix(0, 1'b0, 1'b0);
      if (gap == 2 && $urandom_range(0, 2) == 0) drive_pix(0, 1'b0, 1'b0);
      drive_pix(v, fs && i == 0, 1'b1);
    end
  endtask

  task automatic load_kernel(input int nbeats);
    load_start = 1'b1;
    m_run = 1'b0;
    m_x = 0;
    m_y = 0;
    @(negedge clk);
    load_start = 1'b0;
    chk("w_ready_in_load", w_ready, 1);
    chk("run_ready_in_load", run_ready, 0);
    for (int i = 0; i < nbeats; i++) begin
      w_valid = 1'b1;
      w_in    = DW'(new_k[i]);
      @(negedge clk);
    end
    w_valid = 1'b0;
    if (nbeats == K*K) begin
      kern  = new_k;
      m_run = 1'b1;
      chk("run_ready_after_load", run_ready, 1);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    chk("drain_queue_empty", sb.size(), 0);
    sb.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_run = 1'b0;
    m_x = 0;
    m_y = 0;
    w_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_w_ready", w_ready, 0);
    chk("rst_run_ready", run_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_data_out", data_out, 0);
    sb.delete();
    rst_n = 1'b1;
  endtask

  task automatic rand_kernel();
    for (int i = 0; i < K*K; i++) new_k[i] = int'($urandom_range(0, 511)) - 256;
  endtask

  initial begin
    int n0;
    @(negedge clk);
    do_reset();

    // All-ones kernel over a flat frame
    for (int i = 0; i < K*K; i++) new_k[i] = 1;
    load_kernel(K*K);
    n0 = n_out;
    stream(4 * W, 0, 1'b1, 0);
    wait_drain();
    chk("flat_out_count", n_out - n0, 60);

    // Identity kernel returns the centre pixel
    for (int i = 0; i < K*K; i++) new_k[i] = (i == 4) ? 1 : 0;
    load_kernel(K*K);
    stream(4 * W, 1, 1'b1, 0);
    wait_drain();

    // Most negative-magnitude sum
    for (int i = 0; i < K*K; i++) new_k[i] = -1;
    load_kernel(K*K);
    n0 = n_out;
    stream(3 * W, 2, 1'b1, 0);
    wait_drain();
    chk("neg_out_count", n_out - n0, 30);
    chk("neg_data_bits", data_out, 22'h3FF709);

    // Random data with pix_valid alternating every cycle
    rand_kernel();
    load_kernel(K*K);
    stream(4 * W, 3, 1'b1, 1);
    wait_drain();

    // Reset during a partial load, idle pixels ignored, then a full reload
    rand_kernel();
    load_kernel(4);
    do_reset();
    n0 = n_out;
    stream(2 * W, 3, 1'b0, 0);
    chk("idle_no_out", n_out - n0, 0);
    rand_kernel();
    load_kernel(K*K);
    stream(3 * W, 3, 1'b0, 2);
    wait_drain();

    // Kernel swap mid-frame: in-flight results keep the old kernel
    rand_kernel();
    load_kernel(K*K);
    stream(3 * W + 10, 3, 1'b1, 2);
    rand_kernel();
    load_kernel(K*K);
    stream(3 * W, 3, 1'b1, 2);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
